// File: rtl/ot_frame_sched.sv
// ---------------------------------------------------------------------------
// ot_frame_sched
//   Front-end sequencer for the OT nibble-stream datapath. Nibbles are
//   collected into frames of FRAME_LEN nibbles, double-buffered in two slots,
//   issued in arrival order to a shared compute engine (start/done handshake)
//   and each engine result is serialized MSB-first on a 1-bit stream.
//
// Parameters
//   FRAME_LEN   : nibbles per frame (2..16)
//   RES_BITS    : engine result width / serialized length (1..32)
//   ENG_TIMEOUT : engine watchdog limit in WAIT cycles (watchdog build only)
//
// Optional feature
//   OT_SCHED_WDOG_EN : when defined, a watchdog runs while waiting for the
//                      engine; on expiry an all-ones result is streamed.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   nibble valid this cycle
//   data       in   input nibble
//   eng_start  out  one-cycle pulse, engine latches eng_data
//   eng_data   out  frame being issued, first-received nibble in MSBs
//   eng_done   in   one-cycle pulse, eng_result valid
//   eng_result in   engine result
//   out_valid  out  serialized result bit valid
//   result     out  serialized result bit
//   ovf        out  sticky overflow flag
// ---------------------------------------------------------------------------
module ot_frame_sched #(
    parameter int FRAME_LEN   = 4,
    parameter int RES_BITS    = 8,
    parameter int ENG_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [3:0]             data,
    output logic                   eng_start,
    output logic [4*FRAME_LEN-1:0] eng_data,
    input  logic                   eng_done,
    input  logic [RES_BITS-1:0]    eng_result,
    output logic                   out_valid,
    output logic                   result,
    output logic                   ovf
);

    localparam int FW = 4 * FRAME_LEN;
    localparam int CW = $clog2(FRAME_LEN);
    localparam int IW = (RES_BITS > 1) ? $clog2(RES_BITS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, SER} state_t;

    state_t                state_q, state_d;
    logic [FW-1:0]         slot_q [2];
    logic [FW-1:0]         slot_d [2];
    logic [1:0]            full_q, full_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  drop_q, drop_d;
    logic                  ovf_q, ovf_d;
    logic [RES_BITS-1:0]   shreg_q, shreg_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  out_valid_q, out_valid_d;
    logic                  result_q, result_d;
    logic [FW-1:0]         eng_data_q, eng_data_d;
`ifdef OT_SCHED_WDOG_EN
    logic [31:0]           wdog_q, wdog_d;
`endif

    logic issue;
    logic slot_free;
    logic drop_cur;
    int   nib_lsb;

    // Start is combinational so it appears in the cycle right after the slot
    // is marked full; the issued frame is also kept in eng_data_q so that
    // eng_data holds its last issued value between starts.
    assign issue     = (state_q == IDLE) && full_q[rd_ptr_q];
    assign eng_start = issue;
    assign eng_data  = issue ? slot_q[rd_ptr_q] : eng_data_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ovf       = ovf_q;

    // A slot being released by eng_start on this very edge counts as free,
    // so a frame starting on that edge is not dropped needlessly.
    assign slot_free = !full_q[wr_ptr_q] || (issue && (rd_ptr_q == wr_ptr_q));
    // Drop decision is taken on the first nibble and held for the frame.
    assign drop_cur  = (cnt_q == '0) ? !slot_free : drop_q;

    always_comb begin
        slot_d      = slot_q;
        full_d      = full_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        drop_d      = drop_q;
        ovf_d       = ovf_q;
        state_d     = state_q;
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        eng_data_d  = eng_data_q;
        nib_lsb     = FW - 4 - 4 * int'(cnt_q);
`ifdef OT_SCHED_WDOG_EN
        wdog_d      = '0;
`endif

        // Release happens before fill so a same-edge free and fill both land.
        if (issue) begin
            full_d[rd_ptr_q] = 1'b0;
        end

        // Collector
        if (in_valid) begin
            if (drop_cur) begin
                ovf_d = 1'b1;
            end else begin
                slot_d[wr_ptr_q][nib_lsb +: 4] = data;
            end
            if (cnt_q == CW'(FRAME_LEN - 1)) begin
                cnt_d  = '0;
                drop_d = 1'b0;
                if (!drop_cur) begin
                    full_d[wr_ptr_q] = 1'b1;
                    wr_ptr_d         = ~wr_ptr_q;
                end
            end else begin
                cnt_d  = cnt_q + 1'b1;
                drop_d = drop_cur;
            end
        end

        // Engine FSM
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d    = WAIT;
                    rd_ptr_d   = ~rd_ptr_q;
                    eng_data_d = slot_q[rd_ptr_q];
                end
            end
            WAIT: begin
                if (eng_done) begin
                    shreg_d = eng_result;
                    idx_d   = '0;
                    state_d = SER;
`ifdef OT_SCHED_WDOG_EN
                end else if (wdog_q == 32'(ENG_TIMEOUT - 1)) begin
                    shreg_d = '1;
                    idx_d   = '0;
                    state_d = SER;
                end else begin
                    wdog_d  = wdog_q + 32'd1;
`endif
                end
            end
            SER: begin
                shreg_d = shreg_q << 1;
                if (idx_q == IW'(RES_BITS - 1)) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Output bits are registered copies of the next SER state.
        out_valid_d = (state_d == SER);
        result_d    = out_valid_d & shreg_d[RES_BITS-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            slot_q[0]   <= '0;
            slot_q[1]   <= '0;
            full_q      <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= '0;
            drop_q      <= 1'b0;
            ovf_q       <= 1'b0;
            shreg_q     <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= 1'b0;
            eng_data_q  <= '0;
`ifdef OT_SCHED_WDOG_EN
            wdog_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            slot_q[0]   <= slot_d[0];
            slot_q[1]   <= slot_d[1];
            full_q      <= full_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
            ovf_q       <= ovf_d;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            eng_data_q  <= eng_data_d;
`ifdef OT_SCHED_WDOG_EN
            wdog_q      <= wdog_d;
`endif
        end
    end

endmodule
